// File: rtl/shift_seq_ctrl_if.sv
// Command, counter and shift-register signal bundle for shift_seq_ctrl.
// With ROTATE_EN defined, the bundle also carries rot and sh_q.
interface shift_seq_ctrl_if #(
  parameter int WIDTH = 32,
  parameter int CW    = 6
);
  logic             start;
  logic [WIDTH-1:0] data_in;
  logic [CW-1:0]    amt;
  logic             dir;
  logic             abort;
  logic [CW-1:0]    ctr_q;
  logic [1:0]       ctr_m;
  logic [CW-1:0]    ctr_d;
  logic [1:0]       sh_m;
  logic [WIDTH-1:0] sh_d;
  logic             busy;
  logic             done;
`ifdef ROTATE_EN
  logic             rot;
  logic [WIDTH-1:0] sh_q;

  modport slave (
    input  start, data_in, amt, dir, abort, ctr_q, rot, sh_q,
    output ctr_m, ctr_d, sh_m, sh_d, busy, done
  );
  modport master (
    output start, data_in, amt, dir, abort, ctr_q, rot, sh_q,
    input  ctr_m, ctr_d, sh_m, sh_d, busy, done
  );
`else
  modport slave (
    input  start, data_in, amt, dir, abort, ctr_q,
    output ctr_m, ctr_d, sh_m, sh_d, busy, done
  );
  modport master (
    output start, data_in, amt, dir, abort, ctr_q,
    input  ctr_m, ctr_d, sh_m, sh_d, busy, done
  );
`endif
endinterface

// File: rtl/shift_seq_ctrl.sv
// Sequencer driving a ud_counter / shift-register pair: load, N single-bit shifts, done pulse.
// Optional macro ROTATE_EN adds end-around rotation using the shift register's Q.
//
// state | meaning
// IDLE  | waiting for start, modes hold
// LOAD  | parallel-load counter with amount and shift register with operand
// SHIFT | one shift plus counter decrement per cycle until counter reads zero
// DONE  | one-cycle done pulse, back to IDLE
module shift_seq_ctrl #(
  parameter int WIDTH = 32,
  parameter int CW    = 6
) (
  input  logic              clk,
  input  logic              clr,
  shift_seq_ctrl_if.slave   bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_SHIFT = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [1:0] M_HOLD = 2'b00;
  localparam logic [1:0] M_INC  = 2'b01;
  localparam logic [1:0] M_DEC  = 2'b10;
  localparam logic [1:0] M_LOAD = 2'b11;

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_data;
  logic [CW-1:0]    r_amt;
  logic             r_dir;
  logic             r_rot;

  logic [1:0]       w_next;
  logic [1:0]       w_ctr_m;
  logic [CW-1:0]    w_ctr_d;
  logic [1:0]       w_sh_m;
  logic [WIDTH-1:0] w_sh_d;
  logic             w_done;
  logic [31:0]      w_amt_ext;
  logic [CW-1:0]    w_amt_cap;
  logic [WIDTH-1:0] w_rot_val;
  logic             w_rot_in;

  // Amounts beyond WIDTH give the same all-shifted-out result, so cap them.
  assign w_amt_ext = 32'(bus.amt);
  assign w_amt_cap = (w_amt_ext > 32'(WIDTH)) ? CW'(WIDTH) : bus.amt;

`ifdef ROTATE_EN
  assign w_rot_in  = bus.rot;
  assign w_rot_val = r_dir ? {bus.sh_q[0], bus.sh_q[WIDTH-1:1]}
                           : {bus.sh_q[WIDTH-2:0], bus.sh_q[WIDTH-1]};
`else
  assign w_rot_in  = 1'b0;
  assign w_rot_val = '0;
`endif

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_state <= S_IDLE;
      r_data  <= '0;
      r_amt   <= '0;
      r_dir   <= 1'b0;
      r_rot   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && bus.start) begin
        r_data <= bus.data_in;
        r_amt  <= w_amt_cap;
        r_dir  <= bus.dir;
        r_rot  <= w_rot_in;
      end
    end
  end

  always_comb begin
    w_next  = r_state;
    w_ctr_m = M_HOLD;
    w_ctr_d = '0;
    w_sh_m  = M_HOLD;
    w_sh_d  = '0;
    w_done  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) w_next = S_LOAD;
      end
      S_LOAD: begin
        if (bus.abort) begin
          w_next = S_IDLE;
        end else begin
          w_ctr_m = M_LOAD;
          w_ctr_d = r_amt;
          w_sh_m  = M_LOAD;
          w_sh_d  = r_data;
          w_next  = (r_amt == '0) ? S_DONE : S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (bus.abort) begin
          w_next = S_IDLE;
        end else if (bus.ctr_q != '0) begin
          w_ctr_m = M_DEC;
          if (r_rot) begin
            w_sh_m = M_LOAD;
            w_sh_d = w_rot_val;
          end else begin
            w_sh_m = r_dir ? M_DEC : M_INC;
          end
        end else begin
          w_next = S_DONE;
        end
      end
      default: begin
        w_done = 1'b1;
        w_next = S_IDLE;
      end
    endcase
  end

  assign bus.ctr_m = w_ctr_m;
  assign bus.ctr_d = w_ctr_d;
  assign bus.sh_m  = w_sh_m;
  assign bus.sh_d  = w_sh_d;
  assign bus.busy  = (r_state != S_IDLE);
  assign bus.done  = w_done;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Scoreboard bench for shift_seq_ctrl with behavioural ud_counter and shift-register models.
// Define ROTATE_EN at compile time to exercise the rotation vectors.
module tb_shift_seq_ctrl;
  localparam int WIDTH = 32;
  localparam int CW    = 6;

  logic clk = 1'b0;
  logic clr = 1'b1;
  always #5 clk = ~clk;

  shift_seq_ctrl_if #(.WIDTH(WIDTH), .CW(CW)) bus ();
  shift_seq_ctrl #(.WIDTH(WIDTH), .CW(CW)) dut (.clk(clk), .clr(clr), .bus(bus));

  logic [CW-1:0]    r_ctr;
  logic [WIDTH-1:0] r_shq;
  assign bus.ctr_q = r_ctr;
`ifdef ROTATE_EN
  assign bus.sh_q = r_shq;
`endif

  // Downstream models; their active-low clear is tied to ~clr.
  always @(posedge clk or posedge clr) begin
    if (clr) begin
      r_ctr <= '0;
      r_shq <= '0;
    end else begin
      case (bus.ctr_m)
        2'b01:   r_ctr <= r_ctr + 1'b1;
        2'b10:   r_ctr <= r_ctr - 1'b1;
        2'b11:   r_ctr <= bus.ctr_d;
        default: r_ctr <= r_ctr;
      endcase
      case (bus.sh_m)
        2'b01:   r_shq <= r_shq << 1;
        2'b10:   r_shq <= r_shq >> 1;
        2'b11:   r_shq <= bus.sh_d;
        default: r_shq <= r_shq;
      endcase
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] q;
    int          done_cyc;
    int          shl;
    int          shr;
    string       name;
  } exp_t;

  exp_t sbq[$];
  int n_vec = 0;
  int n_err = 0;
  int cnt_shl = 0;
  int cnt_shr = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  // Monitor: counts shift codes and scores every done pulse against the queue head.
  always @(negedge clk) begin
    exp_t e;
    if (!clr) begin
      if (bus.sh_m == 2'b01) cnt_shl++;
      else if (bus.sh_m == 2'b10) cnt_shr++;
      if (bus.done) begin
        if (sbq.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = sbq.pop_front();
          chk({e.name, "_q"}, r_shq, e.q);
          chk({e.name, "_done_cyc"}, 32'(cyc), 32'(e.done_cyc));
          chk({e.name, "_shl_codes"}, 32'(cnt_shl), 32'(e.shl));
          chk({e.name, "_shr_codes"}, 32'(cnt_shr), 32'(e.shr));
        end
      end
    end
  end

  task automatic drive_start(input logic [31:0] d, input logic [CW-1:0] a, input logic dr,
                             input logic rt, input logic ab);
    bus.start   = 1'b1;
    bus.data_in = d;
    bus.amt     = a;
    bus.dir     = dr;
    bus.abort   = ab;
`ifdef ROTATE_EN
    bus.rot     = rt;
`else
    if (rt) $display("note: rot requested without ROTATE_EN");
`endif
  endtask

  task automatic release_inputs();
    bus.start = 1'b0;
    bus.abort = 1'b0;
`ifdef ROTATE_EN
    bus.rot   = 1'b0;
`endif
  endtask

  task automatic wait_drained(input string nm);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (sbq.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      chk({nm, "_timeout"}, 32'd1, 32'd0);
      sbq.delete();
    end
  endtask

  // One scored command; extra_start pulses start again while the command is busy.
  task automatic run(input string nm, input logic [31:0] d, input logic [CW-1:0] a,
                     input logic dr, input logic rt, input logic ab, input bit extra_start,
                     input logic [31:0] q, input int lat, input int shl, input int shr);
    exp_t e;
    @(negedge clk);
    drive_start(d, a, dr, rt, ab);
    cnt_shl = 0;
    cnt_shr = 0;
    e.q = q; e.done_cyc = cyc + lat; e.shl = shl; e.shr = shr; e.name = nm;
    sbq.push_back(e);
    @(negedge clk);
    release_inputs();
    if (extra_start) begin
      @(negedge clk);
      @(negedge clk);
      drive_start(32'hFFFF_FFFF, 6'd1, 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      release_inputs();
    end
    wait_drained(nm);
  endtask

  initial begin
    bus.start   = 1'b0;
    bus.data_in = '0;
    bus.amt     = '0;
    bus.dir     = 1'b0;
    bus.abort   = 1'b0;
`ifdef ROTATE_EN
    bus.rot     = 1'b0;
`endif
    @(negedge clk);
    @(negedge clk);
    chk("rst_busy",  32'(bus.busy),  32'd0);
    chk("rst_done",  32'(bus.done),  32'd0);
    chk("rst_ctr_m", 32'(bus.ctr_m), 32'd0);
    chk("rst_sh_m",  32'(bus.sh_m),  32'd0);
    chk("rst_ctr_d", 32'(bus.ctr_d), 32'd0);
    chk("rst_sh_d",  bus.sh_d,       32'd0);
    clr = 1'b0;
    @(negedge clk);

    run("shl4",      32'h0000_00F0, 6'd4,  1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0F00, 7,  4,  0);
    run("amt0_abrt", 32'h8000_0001, 6'd0,  1'b1, 1'b0, 1'b1, 1'b0, 32'h8000_0001, 2,  0,  0);
    run("clamp63",   32'hFFFF_FFFF, 6'd63, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 35, 0,  32);
    run("shr5",      32'h8000_0000, 6'd5,  1'b1, 1'b0, 1'b0, 1'b0, 32'h0400_0000, 8,  0,  5);
    run("shr4",      32'h1234_5678, 6'd4,  1'b1, 1'b0, 1'b0, 1'b0, 32'h0123_4567, 7,  0,  4);
    run("clamp33",   32'h0000_0001, 6'd33, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 35, 32, 0);
    run("amt32",     32'h0000_0001, 6'd32, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 35, 32, 0);
    run("busy_strt", 32'h0000_0003, 6'd5,  1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0060, 8,  5,  0);

    // Abort in the third SHIFT cycle: two shifts land, the third is suppressed.
    @(negedge clk);
    drive_start(32'h0000_0001, 6'd10, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    release_inputs();
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    bus.abort = 1'b1;
    #1;
    chk("abort_sh_m",  32'(bus.sh_m),  32'd0);
    chk("abort_ctr_m", 32'(bus.ctr_m), 32'd0);
    @(negedge clk);
    bus.abort = 1'b0;
    chk("abort_busy", 32'(bus.busy), 32'd0);
    repeat (3) @(negedge clk);
    chk("abort_q",   r_shq,        32'h0000_0004);
    chk("abort_ctr", 32'(r_ctr),   32'd8);

    // clr in the middle of SHIFT.
    @(negedge clk);
    drive_start(32'hFFFF_0000, 6'd20, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    release_inputs();
    repeat (4) @(negedge clk);
    chk("mid_busy_pre", 32'(bus.busy), 32'd1);
    clr = 1'b1;
    #1;
    chk("clr_busy",  32'(bus.busy),  32'd0);
    chk("clr_ctr_m", 32'(bus.ctr_m), 32'd0);
    chk("clr_sh_m",  32'(bus.sh_m),  32'd0);
    chk("clr_done",  32'(bus.done),  32'd0);
    @(negedge clk);
    clr = 1'b0;
    repeat (2) @(negedge clk);

`ifdef ROTATE_EN
    run("rotl1", 32'h8000_0001, 6'd1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0003, 4, 0, 0);
    run("rotr1", 32'h8000_0001, 6'd1, 1'b1, 1'b1, 1'b0, 1'b0, 32'hC000_0000, 4, 0, 0);
    run("rotl4", 32'h8000_0001, 6'd4, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0018, 7, 0, 0);
`endif

    run("post_shl1", 32'h0000_0001, 6'd1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0002, 4, 1, 0);
    repeat (5) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
